// File: rtl/core_pipe_wb.sv
// Writeback stage: completes the instruction held in the s3_* registers by
// collecting memory responses, performing CSR accesses, writing GPRs and raising traps.
module core_pipe_wb #(
  parameter int XLEN = 64
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            s3_valid,
  output logic            s3_ready,
  input  logic            s3_full,
  input  logic [XLEN-1:0] s3_pc,
  input  logic [31:0]     s3_instr,
  input  logic [XLEN-1:0] s3_wdata,
  input  logic [4:0]      s3_rd,
  input  logic [6:0]      s3_lsu_op,
  input  logic [3:0]      s3_csr_op,
  input  logic [11:0]     s3_csr_addr,
  input  logic [1:0]      s3_wb_op,
  input  logic            s3_trap,
  input  logic            dmem_rsp_valid,
  input  logic            dmem_rsp_err,
  input  logic [XLEN-1:0] dmem_rsp_rdata,
  output logic            csr_en,
  output logic [3:0]      csr_op,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic            csr_error,
  output logic            rd_wen,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_wdata,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_pc,
  output logic [6:0]      trap_cause,
  input  logic            trap_ack,
  output logic            instr_ret,
  output logic [1:0]      dbg_state
);
  localparam int XL = XLEN - 1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_TRAP     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        retired_q, retired_d;
  logic        trap_valid_q, trap_valid_d;
  logic [XL:0] trap_pc_q, trap_pc_d;
  logic [6:0]  trap_cause_q, trap_cause_d;

  logic        is_load, is_store, is_lsu, active, misaligned;
  logic        complete, retire, csr_access, go_trap;
  logic [6:0]  cause_new;
  logic [XL:0] shifted, load_data, wb_data;
  logic        unused_instr;

  assign unused_instr = ^s3_instr;
  assign is_load  = s3_lsu_op[0];
  assign is_store = s3_lsu_op[1];
  assign is_lsu   = is_load || is_store;
  // retired_q masks a payload that already completed but is still held upstream
  assign active   = g_resetn && s3_full && !retired_q;
  assign misaligned = (s3_lsu_op[3] && s3_wdata[0]) ||
                      (s3_lsu_op[4] && (|s3_wdata[1:0])) ||
                      (s3_lsu_op[5] && (|s3_wdata[2:0]));

  always_comb begin
    complete   = 1'b0;
    csr_access = 1'b0;
    go_trap    = 1'b0;
    cause_new  = 7'd2;
    state_d    = state_q;
    case (state_q)
      ST_RUN: begin
        if (active) begin
          if (s3_trap) begin
            go_trap = 1'b1;
            if (misaligned && is_load)       cause_new = 7'd4;
            else if (misaligned && is_store) cause_new = 7'd6;
          end else if (is_lsu) begin
            if (dmem_rsp_valid) begin
              if (dmem_rsp_err) begin
                go_trap   = 1'b1;
                cause_new = is_load ? 7'd5 : 7'd7;
              end else begin
                complete = 1'b1;
              end
            end else begin
              state_d = ST_WAIT_MEM;
            end
          end else if (s3_wb_op == 2'b11) begin
            csr_access = 1'b1;
            if (csr_error) go_trap  = 1'b1;
            else           complete = 1'b1;
          end else begin
            complete = 1'b1;
          end
        end
      end
      ST_WAIT_MEM: begin
        if (active && dmem_rsp_valid) begin
          if (dmem_rsp_err) begin
            go_trap   = 1'b1;
            cause_new = is_load ? 7'd5 : 7'd7;
          end else begin
            complete = 1'b1;
          end
        end
      end
      ST_TRAP: begin
        if (g_resetn && trap_valid_q && trap_ack) complete = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    if (go_trap)       state_d = ST_TRAP;
    else if (complete) state_d = ST_RUN;

    trap_valid_d = trap_valid_q;
    trap_pc_d    = trap_pc_q;
    trap_cause_d = trap_cause_q;
    if (go_trap) begin
      trap_valid_d = 1'b1;
      trap_pc_d    = s3_pc;
      trap_cause_d = cause_new;
    end else if (complete && state_q == ST_TRAP) begin
      trap_valid_d = 1'b0;
      trap_pc_d    = '0;
      trap_cause_d = '0;
    end

    // A new accept takes priority: the next payload must be treated as fresh
    if (s3_valid && s3_ready) retired_d = 1'b0;
    else if (complete)        retired_d = 1'b1;
    else                      retired_d = retired_q;
  end

  assign retire = complete && (state_q != ST_TRAP);

  assign shifted = dmem_rsp_rdata >> {s3_wdata[2:0], 3'b000};

  always_comb begin
    load_data = shifted;
    if (s3_lsu_op[2])
      load_data = {{(XLEN-8){s3_lsu_op[6] && shifted[7]}}, shifted[7:0]};
    else if (s3_lsu_op[3])
      load_data = {{(XLEN-16){s3_lsu_op[6] && shifted[15]}}, shifted[15:0]};
    else if (s3_lsu_op[4])
      load_data = {{(XLEN-32){s3_lsu_op[6] && shifted[31]}}, shifted[31:0]};
  end

  always_comb begin
    case (s3_wb_op)
      2'b01:   wb_data = s3_wdata;
      2'b10:   wb_data = load_data;
      2'b11:   wb_data = csr_rdata;
      default: wb_data = '0;
    endcase
  end

  assign rd_wen     = retire && (s3_wb_op != 2'b00) && (s3_rd != 5'd0) && !is_store;
  assign rd_addr    = rd_wen ? s3_rd : 5'd0;
  assign rd_wdata   = rd_wen ? wb_data : '0;
  assign csr_en     = csr_access;
  assign csr_op     = csr_access ? s3_csr_op : 4'd0;
  assign csr_addr   = csr_access ? s3_csr_addr : 12'd0;
  assign csr_wdata  = csr_access ? s3_wdata : '0;
  assign instr_ret  = retire;
  assign s3_ready   = g_resetn && (!active || complete);
  assign trap_valid = trap_valid_q;
  assign trap_pc    = trap_pc_q;
  assign trap_cause = trap_cause_q;
  assign dbg_state  = state_q;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q      <= ST_RUN;
      retired_q    <= 1'b0;
      trap_valid_q <= 1'b0;
      trap_pc_q    <= '0;
      trap_cause_q <= '0;
    end else begin
      state_q      <= state_d;
      retired_q    <= retired_d;
      trap_valid_q <= trap_valid_d;
      trap_pc_q    <= trap_pc_d;
      trap_cause_q <= trap_cause_d;
    end
  end
endmodule

// File: doc/core_pipe_wb.md
Name: core_pipe_wb

Overview:
- Writeback stage, directly downstream of the execute stage.
- Consumes the registered s3_* instruction held by execute and completes it:
  - collects load/store responses from data memory;
  - performs CSR accesses;
  - writes the GPR file;
  - raises traps.
- Drives s3_ready back to execute, which gates pipeline progress.

Parameters:
- XLEN, 64, data width; XL = XLEN-1.

Ports:
- g_clk  in  1  clock; g_resetn  in  1  reset (synchronous, active-low).
- s3_valid  in  1  execute is offering a new instruction this cycle.
- s3_ready  out  1  writeback can accept a new instruction.
- s3_full  in  1  the s3_* registers hold an instruction.
- s3_pc  in  XLEN  instruction PC.
- s3_instr  in  32  instruction word.
- s3_wdata  in  XLEN  result data, or memory address for LSU ops.
- s3_rd  in  5  destination register.
- s3_lsu_op  in  7  {sext,dbl,word,half,byte,store,load}, with load at bit 0.
- s3_csr_op  in  4  {clr,set,wr,rd}, with rd at bit 0.
- s3_csr_addr  in  12  CSR address.
- s3_wb_op  in  2  writeback source: 00 none, 01 wdata, 10 lsu, 11 csr.
- s3_trap  in  1  execute-detected trap.
- dmem_rsp_valid  in  1  data memory response valid.
- dmem_rsp_err  in  1  bus error on the response.
- dmem_rsp_rdata  in  XLEN  response data, doubleword aligned.
- csr_en  out  1  CSR access strobe.
- csr_op  out  4  copy of s3_csr_op while csr_en is high.
- csr_addr  out  12  CSR address.
- csr_wdata  out  XLEN  value driven from s3_wdata.
- csr_rdata  in  XLEN  CSR read data, combinational.
- csr_error  in  1  illegal CSR access, combinational.
- rd_wen  out  1  GPR write enable.
- rd_addr  out  5  GPR write address.
- rd_wdata  out  XLEN  GPR write data.
- trap_valid  out  1  trap request to the trap/fetch unit.
- trap_pc  out  XLEN  faulting PC.
- trap_cause  out  7  trap cause code.
- trap_ack  in  1  trap accepted.
- instr_ret  out  1  one-cycle retire pulse.

Behaviour:
- Reset: all outputs 0; state RUN; retired flag 0.
- active = s3_full && !retired.
  - retired sets on completion; clears on s3_valid && s3_ready.
  - This prevents re-retiring a stale s3_* payload.
- Completion conditions for an active instruction:
  - wb_op 00/01: completes same cycle.
  - wb_op 11: completes same cycle; csr_en=1 for exactly that cycle.
  - LSU (load|store): completes in the cycle dmem_rsp_valid=1.
  - Trap: completes in the cycle trap_ack=1.
- Combinational output: s3_ready = !active || completes_this_cycle.
- State RUN:
  - active && s3_trap → TRAP.
    - cause 4 = load misaligned; 6 = store misaligned; otherwise 2.
    - No GPR write.
  - active && LSU && !dmem_rsp_valid → WAIT_MEM.
  - An LSU response in the same cycle as becoming active completes immediately (0 wait).
  - CSR with csr_error=1 → TRAP with cause 2; no write.
- State WAIT_MEM: stay until dmem_rsp_valid.
  - err=1 → TRAP with cause 5 (load) or 7 (store).
  - Otherwise complete → RUN.
- State TRAP:
  - trap_valid=1 with trap_pc/trap_cause stable.
  - Hold until trap_ack; then complete, pulse instr_ret=0, return to RUN.
  - A trapped instruction never retires.
- Load data path:
  - off = s3_wdata[2:0]; shifted = rdata >> (8*off).
  - Select width byte/half/word/dbl; zero-extend, or sign-extend if sext.
- GPR write:
  - rd_wen=1 only in the completion cycle, non-trapping, wb_op≠00, and s3_rd≠0.
  - Stores never write.
  - rd_wdata is selected by wb_op: wdata / load data / csr_rdata.
- instr_ret pulses in every non-trap completion cycle.
- Stray response: dmem_rsp_valid while not LSU-active is ignored, e.g. after a reset that abandoned WAIT_MEM.
- Reset mid-operation:
  - WAIT_MEM/TRAP are abandoned; state returns to RUN.
  - No write and no retire occur.
- Simultaneous trap_ack and a new s3_valid: the new instruction is accepted in the same cycle.

Test Plan:
- ALU result: wb_op=01, rd=5, wdata=0x1234 → same cycle: rd_wen=1, rd_addr=5, rd_wdata=0x1234, instr_ret=1, s3_ready=1. With rd=0: rd_wen=0 and instr_ret=1.
- Signed byte load at addr ...03, rdata=0x00000000_80000000 (byte 3 = 0x80):
  - Response 2 cycles later → s3_ready=0 for 2 cycles.
  - Then rd_wdata=0xFFFF_FFFF_FFFF_FF80. Repeat with sext=0 → 0x80.
- Store with dmem_rsp_err=1 → trap_valid=1, cause 7; held 3 cycles until trap_ack; no rd_wen; instr_ret=0.
- CSR read, csr_rdata=0xABCD → csr_en pulse, rd_wdata=0xABCD. With csr_error=1 → trap cause 2.
- s3_full held high with no new s3_valid for 4 cycles → exactly one instr_ret and one rd_wen.
- Reset asserted during WAIT_MEM, then a late dmem_rsp_valid → no write, state RUN, all outputs 0.
